// File: rtl/alu_pkg.sv
// Shared encodings and constants for the add/sub execute unit.
// Op codes, saturation limits and flag bit positions.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD    = 2'b00,
      OP_SUB    = 2'b01,
      OP_PADDSB = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   localparam logic [15:0] SAT_POS16 = 16'h7FFF;
   localparam logic [15:0] SAT_NEG16 = 16'h8000;
   localparam logic [3:0]  SAT_POS4  = 4'h7;
   localparam logic [3:0]  SAT_NEG4  = 4'h8;

   localparam int FLG_N = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_V = 0;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice: sum, group generate/propagate, signed overflow.
// Purely combinational; b_i is the already-conditioned (possibly inverted) operand.
module cla4_slice (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       tg_o,
   output logic       tp_o,
   output logic       ovfl_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   always_comb begin
      g = a_i & b_i;
      p = a_i ^ b_i;
      c[0] = cin_i;
      c[1] = g[0] | (p[0] & cin_i);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
      sum_o = p ^ c;
      tg_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      tp_o = &p;
      ovfl_o = (a_i[3] == b_i[3]) & (sum_o[3] != a_i[3]);
   end

endmodule

// File: rtl/addsub16_pipe.sv
// Two-stage signed ADD/SUB (saturating when SAT=1) with N/Z/V flags over valid/ready.
// Define ADDSUB_PADDSB_EN to add per-nibble saturating PADDSB on op 10; otherwise op 10 is ADD.
module addsub16_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter bit SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [2:0]       flag_nzv,
   output logic             flag_we
);

   localparam int NIB = WIDTH / 4;
   localparam logic [WIDTH-1:0] SAT_POS =
      (WIDTH == 16) ? WIDTH'(SAT_POS16) : {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG =
      (WIDTH == 16) ? WIDTH'(SAT_NEG16) : {1'b1, {(WIDTH-1){1'b0}}};

   // ---------------- handshake ----------------
   logic s1_vld_q, s1_vld_d;
   logic out_vld_q;
   logic s1_adv;
   logic accept;
   logic sub;

   always_comb begin
      s1_adv   = s1_vld_q & (!out_vld_q | out_ready);
      in_ready = !s1_vld_q | s1_adv;
      accept   = in_valid & in_ready & !flush;
      sub      = (op == OP_SUB);
      s1_vld_d = s1_vld_q;
      if (flush)
         s1_vld_d = 1'b0;
      else if (in_ready)
         s1_vld_d = in_valid;
   end

   // ---------------- stage 1 registers ----------------
   logic [WIDTH-1:0] s1_a_q, s1_b_q;
   logic             s1_cin_q;
`ifdef ADDSUB_PADDSB_EN
   op_e              s1_op_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s1_cin_q <= 1'b0;
`ifdef ADDSUB_PADDSB_EN
         s1_op_q  <= OP_ADD;
`endif
      end else begin
         s1_vld_q <= s1_vld_d;
         if (accept) begin
            s1_a_q   <= a;
            s1_b_q   <= b ^ {WIDTH{sub}};
            s1_cin_q <= sub;
`ifdef ADDSUB_PADDSB_EN
            s1_op_q  <= op_e'(op);
`endif
         end
      end
   end

   // ---------------- stage 2 datapath ----------------
   logic [NIB:0]     c;
   logic [NIB-1:0]   tg, tp, ovfl;
   logic [WIDTH-1:0] sum;

   genvar gi;
   generate
      for (gi = 0; gi < NIB; gi++) begin : g_slice
         cla4_slice u_slice (
            .a_i   (s1_a_q[4*gi +: 4]),
            .b_i   (s1_b_q[4*gi +: 4]),
            .cin_i (c[gi]),
            .sum_o (sum[4*gi +: 4]),
            .tg_o  (tg[gi]),
            .tp_o  (tp[gi]),
            .ovfl_o(ovfl[gi])
         );
      end
   endgenerate

`ifdef ADDSUB_PADDSB_EN
   logic is_paddsb;
   assign is_paddsb = (s1_op_q == OP_PADDSB);
`endif

   // Group carry tree; PADDSB isolates the nibbles.
   always_comb begin
      c[0] = s1_cin_q;
      for (int i = 0; i < NIB; i++) begin
`ifdef ADDSUB_PADDSB_EN
         c[i+1] = is_paddsb ? 1'b0 : (tg[i] | (tp[i] & c[i]));
`else
         c[i+1] = tg[i] | (tp[i] & c[i]);
`endif
      end
   end

   logic             unused_bits;
`ifdef ADDSUB_PADDSB_EN
   assign unused_bits = c[NIB];
`else
   assign unused_bits = ^{c[NIB], ovfl[NIB-2:0]};
`endif

   logic [WIDTH-1:0] res_d;
   logic [2:0]       nzv_d;
   logic             we_d;
   logic             v;

   always_comb begin
      res_d = sum;
      v     = ovfl[NIB-1];
      we_d  = 1'b1;
      if (SAT && v)
         res_d = s1_a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
`ifdef ADDSUB_PADDSB_EN
      if (is_paddsb) begin
         res_d = sum;
         v     = 1'b0;
         we_d  = 1'b0;
         for (int n = 0; n < NIB; n++) begin
            if (ovfl[n])
               res_d[4*n +: 4] = s1_a_q[4*n+3] ? SAT_NEG4 : SAT_POS4;
         end
      end
`endif
      // Flags always reflect the value actually written back.
      nzv_d        = '0;
      nzv_d[FLG_N] = res_d[WIDTH-1];
      nzv_d[FLG_Z] = (res_d == '0);
      nzv_d[FLG_V] = v;
   end

   // ---------------- stage 2 registers ----------------
   logic [WIDTH-1:0] res_q;
   logic [2:0]       nzv_q;
   logic             we_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         res_q     <= '0;
         nzv_q     <= '0;
         we_q      <= 1'b0;
      end else if (flush) begin
         out_vld_q <= 1'b0;
      end else if (s1_adv) begin
         out_vld_q <= 1'b1;
         res_q     <= res_d;
         nzv_q     <= nzv_d;
         we_q      <= we_d;
      end else if (out_ready) begin
         out_vld_q <= 1'b0;
      end
   end

   assign out_valid = out_vld_q;
   assign res       = res_q;
   assign flag_nzv  = nzv_q;
   assign flag_we   = we_q;

endmodule

// File: tb/tb_addsub16_pipe.sv
// Directed self-checking bench for addsub16_pipe (default parameters).
module tb_addsub16_pipe;

   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, PADDSB = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic        flush;
   logic        out_valid, out_ready;
   logic [15:0] res;
   logic [2:0]  flag_nzv;
   logic        flag_we;

   int checks   = 0;
   int failures = 0;

   addsub16_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .res      (res),
      .flag_nzv (flag_nzv),
      .flag_we  (flag_we)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
   endtask

   // Single op with out_ready high: checks the two-edge latency and the result.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] er, input logic [2:0] enzv,
                         input logic ewe);
      drive(o, x, y);
      check({tag, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1_vld"}, out_valid, 0);
      tick();
      check({tag, "_vld"}, out_valid, 1);
      check({tag, "_res"}, res, er);
      check({tag, "_nzv"}, flag_nzv, enzv);
      check({tag, "_we"}, flag_we, ewe);
      tick();
      check({tag, "_drained"}, out_valid, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = ADD; a = '0; b = '0;
      flush = 1'b0; out_ready = 1'b1;
      repeat (2) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_res", res, 0);
      check("rst_nzv", flag_nzv, 0);
      check("rst_we", flag_we, 0);
      rst = 1'b0;
      tick();
      check("idle_in_ready", in_ready, 1);

      // Saturation and flags
      run_op("add_sat_pos", ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001, 1'b1);
      run_op("sub_sat_neg", SUB, 16'h8000, 16'h0001, 16'h8000, 3'b101, 1'b1);
      run_op("sub_zero",    SUB, 16'h1234, 16'h1234, 16'h0000, 3'b010, 1'b1);
      run_op("add_plain",   ADD, 16'h1234, 16'h0F0F, 16'h2143, 3'b000, 1'b1);
      run_op("rsvd_as_add", 2'b11, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001, 1'b1);
`ifdef ADDSUB_PADDSB_EN
      run_op("paddsb", PADDSB, 16'h7F81, 16'h1111, 16'h7092, 3'b000, 1'b0);
`else
      run_op("paddsb_as_add", PADDSB, 16'h7F81, 16'h1111, 16'h7FFF, 3'b001, 1'b1);
`endif

      // Back-pressure: three back-to-back ops, out_ready low for three cycles
      out_ready = 1'b0;
      drive(ADD, 16'h0001, 16'h0002);           // A -> 0x0003, 000
      tick();
      check("bp_rdy_after_A", in_ready, 1);
      drive(SUB, 16'h0005, 16'h0007);           // B -> 0xFFFE, 100
      tick();
      check("bp_A_vld", out_valid, 1);
      check("bp_rdy_fall", in_ready, 0);
      drive(ADD, 16'hFFFF, 16'h0001);           // C -> 0x0000, 010
      tick();
      check("bp_stall1_res", res, 16'h0003);
      check("bp_stall1_rdy", in_ready, 0);
      tick();
      check("bp_stall2_res", res, 16'h0003);
      check("bp_stall2_nzv", flag_nzv, 3'b000);
      check("bp_stall2_vld", out_valid, 1);
      out_ready = 1'b1;
      #1;
      check("bp_release_rdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("bp_B_vld", out_valid, 1);
      check("bp_B_res", res, 16'hFFFE);
      check("bp_B_nzv", flag_nzv, 3'b100);
      tick();
      check("bp_C_vld", out_valid, 1);
      check("bp_C_res", res, 16'h0000);
      check("bp_C_nzv", flag_nzv, 3'b010);
      tick();
      check("bp_done_vld", out_valid, 0);

      // Flush with both stages full and in_valid high
      out_ready = 1'b0;
      drive(ADD, 16'h0010, 16'h0020);
      tick();
      drive(ADD, 16'h0030, 16'h0040);
      tick();
      check("fl_full_vld", out_valid, 1);
      drive(ADD, 16'h0050, 16'h0060);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_out_cleared", out_valid, 0);
      check("fl_s1_cleared", in_ready, 1);
      out_ready = 1'b1;
      tick();
      check("fl_nothing_emitted", out_valid, 0);
      // Flush while an accept would otherwise happen
      drive(ADD, 16'h0100, 16'h0200);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      tick();
      check("fl_same_cycle_drop", out_valid, 0);
      run_op("fl_resume", ADD, 16'h0003, 16'h0004, 16'h0007, 3'b000, 1'b1);

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      drive(SUB, 16'h0000, 16'h0001);           // -> 0xFFFF, 100
      tick();
      drive(ADD, 16'h0002, 16'h0002);
      tick();
      in_valid = 1'b0;
      check("ar_before_vld", out_valid, 1);
      check("ar_before_res", res, 16'hFFFF);
      #3 rst = 1'b1;
      #1;
      check("ar_vld", out_valid, 0);
      check("ar_res", res, 0);
      check("ar_nzv", flag_nzv, 0);
      check("ar_we", flag_we, 0);
      check("ar_in_ready", in_ready, 1);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      check("ar_post_vld", out_valid, 0);
      run_op("ar_resume", SUB, 16'h0010, 16'h0020, 16'hFFF0, 3'b100, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
